p1_window_reader: RTL and testbench
===================================

P1_WINDOW_READER -- requirements
Module: p1_window_reader

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 start  input  1  one-cycle pulse; begins a pass over the 12x12 pooled map.
REQ-004 ready  input  1  consumer (conv-2 MAC) can accept a tap this cycle.
REQ-005 rd_en  output  1  memory read strobe for addr.
REQ-006 addr  output  8  pooled-map read address, 0..143, row-major.
REQ-007 tap_row, tap_col  output  3 each  kernel position (0..4) of the data returning this cycle.
REQ-008 first_tap, last_tap  output  1 each  data this cycle is tap (0,0) / tap (4,4) of a window.
REQ-009 out_valid  output  1  memory data plus tap tags are valid this cycle.
REQ-010 pad  output  1  tap is out of bounds; consumer uses 0 (padding build only).
REQ-011 busy, done  output  1 each  pass in progress / pass complete.

Function
REQ-012 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN after last tap issued, DRAIN->DONE after RD_LAT cycles, DONE->RUN on start.
REQ-013 Iteration order: window oy outer, ox, then ky, kx innermost; each 0..N-1 / 0..4.
REQ-014 Without padding N=8; addr = (oy+ky)*12 + (ox+kx); 64 windows x 25 taps = 1600 issues.
REQ-015 One tap issued per cycle in RUN while ready=1; rd_en = RUN & ready & ~pad_tap.
REQ-016 ready=0 freezes all counters and addr; rd_en low; no tap skipped or duplicated.
REQ-017 out_valid, tap_row, tap_col, first_tap, last_tap, pad are delayed exactly RD_LAT=1 cycle from the issue cycle.
REQ-018 out_valid asserted only for cycles following an issue (ready=1 in RUN).
REQ-019 busy high in RUN and DRAIN only.
REQ-020 done goes high on DRAIN->DONE and stays high until next start or reset.
REQ-021 start while busy is ignored.
REQ-022 start and last-tap issue on the same cycle: start ignored.
REQ-023 Address arithmetic in 8 bits; address is never outside 0..143 when rd_en=1.

Reset
REQ-024 reset=0 forces IDLE, all counters 0, addr=0, rd_en=0, out_valid=0, tags=0, pad=0, busy=0, done=0, independent of clk.
REQ-025 Reset mid-pass aborts the pass; no out_valid after reset release until a new start.

Configuration
REQ-026 Macro P1_READ_ZEROPAD_EN defined: 2-pixel zero border, N=12, 144 windows x 25 = 3600 taps; in-map position (r,c) = (oy+ky-2, ox+kx-2); taps with r or c outside 0..11 issue with rd_en=0, pad=1, addr held, still consuming one ready cycle.
REQ-027 Macro undefined: N=8, pad output tied 0, no border logic synthesized.

Structure
REQ-028 Shared package cnn_pkg holds IMG_W=12, KERNEL=5, ADDR_W=8, RD_LAT=1, and the reader state enum.
REQ-029 Sub-module p1_tap_counter (nested ky/kx/ox/oy counter with advance input and wrap flags) is instantiated once; address calc and FSM live in the top.

Verification
REQ-030 start, ready=1: first 25 addrs 0,1,2,3,4,12..16,24..28,36..40,48..52; first_tap on 0, last_tap on 52.
REQ-031 Second window begins addr 1; window (oy=1,ox=0) begins addr 12; final tap addr 143 with last_tap; done high after 1600 out_valid pulses plus 1 cycle.
REQ-032 ready toggled pseudo-randomly: out_valid count still 1600, addr sequence identical to REQ-030/031 after removing stall cycles.
REQ-033 reset=0 asserted at tap 700: all outputs 0 same cycle; new start replays from addr 0.
REQ-034 start pulsed at tap 10 and on last-tap cycle: ignored, sequence and tap count unchanged.
REQ-035 P1_READ_ZEROPAD_EN build: first tap pad=1, rd_en=0; window 0 first real read at (ky=2,kx=2) addr 0; 3600 out_valid pulses total.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the pooled-map window reader.
//   IMG_W   : pooled map edge length (map is IMG_W x IMG_W, row-major)
//   KERNEL  : conv-2 kernel edge length
//   ADDR_W  : pooled-map address width
//   RD_LAT  : memory read latency in cycles (tap tags are delayed to match)
//   reader_state_e : reader FSM encoding, also exported as a debug port
package cnn_pkg;

  localparam int IMG_W  = 12;
  localparam int KERNEL = 5;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

endpackage

// File: rtl/p1_tap_counter.sv
// Nested window/tap counter: kx innermost, then ky, ox, oy outermost.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous return of every counter to 0 (pass start)
//   advance      : step to the next tap (one tap consumed this cycle)
//   ky, kx       : kernel position 0..KERNEL-1
//   oy, ox       : window origin 0..N_WIN-1
//   ky_wrap      : current tap is the last tap of its window
//   oy_wrap      : current tap is the last tap of the whole pass
module p1_tap_counter
  import cnn_pkg::*;
#(
  parameter int N_WIN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] ky,
  output logic [2:0] kx,
  output logic [3:0] oy,
  output logic [3:0] ox,
  output logic       ky_wrap,
  output logic       oy_wrap
);

  logic [2:0] ky_q, ky_d, kx_q, kx_d;
  logic [3:0] oy_q, oy_d, ox_q, ox_d;
  logic       kx_wrap, ox_wrap;

  // Each wrap flag already includes every inner wrap, so it marks the
  // exact tap on which that counter rolls over.
  always_comb begin
    kx_wrap = (kx_q == 3'(KERNEL - 1));
    ky_wrap = kx_wrap && (ky_q == 3'(KERNEL - 1));
    ox_wrap = ky_wrap && (ox_q == 4'(N_WIN - 1));
    oy_wrap = ox_wrap && (oy_q == 4'(N_WIN - 1));
  end

  always_comb begin
    ky_d = ky_q;
    kx_d = kx_q;
    oy_d = oy_q;
    ox_d = ox_q;
    if (clear) begin
      ky_d = '0;
      kx_d = '0;
      oy_d = '0;
      ox_d = '0;
    end else if (advance) begin
      kx_d = kx_wrap ? 3'd0 : kx_q + 3'd1;
      if (kx_wrap) ky_d = ky_wrap ? 3'd0 : ky_q + 3'd1;
      if (ky_wrap) ox_d = ox_wrap ? 4'd0 : ox_q + 4'd1;
      if (ox_wrap) oy_d = oy_wrap ? 4'd0 : oy_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ky_q <= '0;
      kx_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
    end else begin
      ky_q <= ky_d;
      kx_q <= kx_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
    end
  end

  assign ky = ky_q;
  assign kx = kx_q;
  assign oy = oy_q;
  assign ox = ox_q;

endmodule

// File: rtl/p1_window_reader.sv
// Streams every 5x5 window of the 12x12 pooled map to the conv-2 MAC:
// issues one memory read per accepted tap and tags the returning data.
// Optional build macro P1_READ_ZEROPAD_EN adds a 2-pixel zero border
// (12x12 windows, out-of-map taps flagged with pad instead of read).
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, starts a pass from IDLE or DONE
//   ready               : consumer accepts a tap this cycle
//   rd_en, addr         : memory read strobe and row-major address
//   tap_row, tap_col    : kernel position of the data returning this cycle
//   first_tap, last_tap : returning tap is (0,0) / (4,4) of its window
//   out_valid           : returning data and tags are valid
//   pad                 : returning tap is border padding (consumer uses 0)
//   busy, done          : pass in progress / pass complete
//   state_dbg           : current FSM state
//
// Handshake: a tap is issued in exactly the cycles where state is RUN and
// ready=1; its tags appear with out_valid RD_LAT cycles later. ready=0
// holds every counter and the address, so a stall never skips or repeats.
module p1_window_reader
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        tap_row,
  output logic [2:0]        tap_col,
  output logic              first_tap,
  output logic              last_tap,
  output logic              out_valid,
  output logic              pad,
  output logic              busy,
  output logic              done,
  output reader_state_e     state_dbg
);

`ifdef P1_READ_ZEROPAD_EN
  localparam int N_WIN = IMG_W;
  localparam int PAD_W = (KERNEL - 1) / 2;
`else
  localparam int N_WIN = IMG_W - KERNEL + 1;
`endif

  reader_state_e     state_q, state_d;
  logic [1:0]        drain_q, drain_d;
  logic [2:0]        ky, kx;
  logic [3:0]        oy, ox;
  logic              win_last, pass_last;
  logic              issue, start_ok;
  logic [4:0]        row_sum, col_sum;
  logic              pad_tap;
  logic [ADDR_W-1:0] addr_calc;

  logic              out_valid_q, out_valid_d;
  logic [2:0]        tap_row_q, tap_row_d, tap_col_q, tap_col_d;
  logic              first_q, first_d, last_q, last_d;

  always_comb begin
    issue    = (state_q == ST_RUN) && ready;
    start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  p1_tap_counter #(.N_WIN(N_WIN)) u_tap_counter (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (start_ok),
    .advance (issue),
    .ky      (ky),
    .kx      (kx),
    .oy      (oy),
    .ox      (ox),
    .ky_wrap (win_last),
    .oy_wrap (pass_last)
  );

  // Map position of the current tap and its read address (8-bit math).
  always_comb begin
    row_sum = 5'(oy) + 5'(ky);
    col_sum = 5'(ox) + 5'(kx);
`ifdef P1_READ_ZEROPAD_EN
    pad_tap   = (row_sum < 5'(PAD_W)) || (row_sum >= 5'(IMG_W + PAD_W)) ||
                (col_sum < 5'(PAD_W)) || (col_sum >= 5'(IMG_W + PAD_W));
    // Garbage when pad_tap is set; never driven out in that case.
    addr_calc = ADDR_W'(row_sum - 5'(PAD_W)) * ADDR_W'(IMG_W) +
                ADDR_W'(col_sum - 5'(PAD_W));
`else
    pad_tap   = 1'b0;
    addr_calc = ADDR_W'(row_sum) * ADDR_W'(IMG_W) + ADDR_W'(col_sum);
`endif
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // ---- FSM: next state ----
  // A start coinciding with the final issue is in RUN, so it is ignored.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (issue && pass_last) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) state_d = ST_DONE;
        else                           drain_d = drain_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    rd_en     = issue && !pad_tap;
    busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // Tap tags travel with the read; they are zero whenever no tap returns.
  always_comb begin
    out_valid_d = issue;
    tap_row_d   = issue ? ky : 3'd0;
    tap_col_d   = issue ? kx : 3'd0;
    first_d     = issue && (ky == 3'd0) && (kx == 3'd0);
    last_d      = issue && win_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      tap_row_q   <= '0;
      tap_col_q   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      tap_row_q   <= tap_row_d;
      tap_col_q   <= tap_col_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign tap_row   = tap_row_q;
  assign tap_col   = tap_col_q;
  assign first_tap = first_q;
  assign last_tap  = last_q;

`ifdef P1_READ_ZEROPAD_EN
  // Padding taps keep the last real address on the bus.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pad_q, pad_d;

  always_comb begin
    addr_d = (issue && !pad_tap) ? addr_calc : addr_q;
    pad_d  = issue && pad_tap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      pad_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pad_q  <= pad_d;
    end
  end

  assign addr = pad_tap ? addr_q : addr_calc;
  assign pad  = pad_q;
`else
  assign addr = addr_calc;
  assign pad  = 1'b0;
`endif

endmodule

// File: tb/tb_p1_window_reader.sv
// Bench for p1_window_reader: full passes with steady and stalling ready,
// ignored start pulses, and a mid-pass reset followed by a replay.
// Expected addresses and tap tags are queued before each pass; a negedge
// monitor pops and compares whenever rd_en / out_valid is seen.
module tb_p1_window_reader;
  import cnn_pkg::*;

`ifdef P1_READ_ZEROPAD_EN
  localparam int N_WIN = 12;
`else
  localparam int N_WIN = 8;
`endif
  localparam int TOTAL = N_WIN * N_WIN * 25;
  localparam int TW    = 9;  // {pad, first, last, row[2:0], col[2:0]}

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ready;
  logic          rd_en;
  logic [7:0]    addr;
  logic [2:0]    tap_row, tap_col;
  logic          first_tap, last_tap, out_valid, pad, busy, done;
  reader_state_e state_dbg;

  p1_window_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ready     (ready),
    .rd_en     (rd_en),
    .addr      (addr),
    .tap_row   (tap_row),
    .tap_col   (tap_col),
    .first_tap (first_tap),
    .last_tap  (last_tap),
    .out_valid (out_valid),
    .pad       (pad),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- scoreboard state ----
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_addr_q[$];
  logic [TW-1:0] exp_q[$];
  int          iss_cnt   = 0;
  int          pass_ov   = 0;
  int          rd_cnt    = 0;
  logic [7:0]  cap_addr[256];
  logic [7:0]  last_addr = '0;
  bit          done_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference order: oy, ox, ky, kx; address from the map position.
  task automatic build_model();
    int r, c;
    bit p;
    exp_addr_q.delete();
    exp_q.delete();
    for (int oy = 0; oy < N_WIN; oy++)
      for (int ox = 0; ox < N_WIN; ox++)
        for (int ky = 0; ky < 5; ky++)
          for (int kx = 0; kx < 5; kx++) begin
`ifdef P1_READ_ZEROPAD_EN
            r = oy + ky - 2;
            c = ox + kx - 2;
            p = (r < 0) || (r > 11) || (c < 0) || (c > 11);
`else
            r = oy + ky;
            c = ox + kx;
            p = 1'b0;
`endif
            if (!p) exp_addr_q.push_back(8'(r * 12 + c));
            exp_q.push_back({p, (ky == 0 && kx == 0), (ky == 4 && kx == 4),
                             3'(ky), 3'(kx)});
          end
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    logic [7:0]    ea;
    logic [TW-1:0] et;
    if (!reset) begin
      iss_cnt   = 0;
      pass_ov   = 0;
      rd_cnt    = 0;
      done_pend = 0;
    end else begin
      if (start && (state_dbg == ST_IDLE || state_dbg == ST_DONE)) begin
        iss_cnt = 0;
        pass_ov = 0;
        rd_cnt  = 0;
      end
      if (state_dbg == ST_RUN && ready) iss_cnt++;
      if (busy && !ready) chk("rd_en_during_stall", {31'd0, rd_en}, 32'd0);
      if (rd_en) begin
        if (exp_addr_q.size() == 0) chk("rd_en_unexpected", 32'd1, 32'd0);
        else begin
          ea = exp_addr_q.pop_front();
          chk("addr", {24'd0, addr}, {24'd0, ea});
        end
        if (rd_cnt < 256) cap_addr[rd_cnt] = addr;
        last_addr = addr;
        rd_cnt++;
      end
      if (done_pend) begin
        chk("done_after_last", {31'd0, done}, 32'd1);
        done_pend = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", 32'd1, 32'd0);
        else begin
          et = exp_q.pop_front();
          chk("tap_tags", {23'd0, pad, first_tap, last_tap, tap_row, tap_col},
              {23'd0, et});
        end
        if (pass_ov == TOTAL - 1) begin
          chk("done_early", {31'd0, done}, 32'd0);
          done_pend = 1;
        end
        pass_ov++;
      end
    end
  end

  // ---- driver ----
  task automatic run_pass(input bit rand_ready, input bit poke_start,
                          input int reset_at, output bit aborted);
    int n;
    bit fin;
    aborted = 0;
    fin     = 0;
    build_model();
    @(posedge clk); #1;
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin && !aborted; cyc++) begin
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      n     = iss_cnt;
      start = poke_start && (state_dbg == ST_RUN) && (n == 10 || n == TOTAL - 1);
      if (reset_at >= 0 && n == reset_at) begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("reset_mid_outputs",
            {11'd0, rd_en, out_valid, busy, done, pad, first_tap, last_tap,
             tap_row, tap_col, addr}, 32'd0);
        exp_addr_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_quiet", {29'd0, out_valid, busy, done}, 32'd0);
        aborted = 1;
      end else begin
        @(posedge clk); #1;
        if (done) fin = 1;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (!aborted) begin
      chk("pass_finished", {31'd0, fin}, 32'd1);
      chk("done_level", {30'd0, done, busy}, 32'd2);
      chk("out_valid_count", pass_ov, TOTAL);
      chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
      chk("tag_queue_empty", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    bit ab;
    reset = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    #1;
    chk("reset_outputs",
        {11'd0, rd_en, out_valid, busy, done, pad, first_tap, last_tap,
         tap_row, tap_col, addr}, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Pass A: ready held high, stray starts at tap 10 and on the last tap.
    run_pass(1'b0, 1'b1, -1, ab);
`ifndef P1_READ_ZEROPAD_EN
    chk("first_addr",       {24'd0, cap_addr[0]},   32'd0);
    chk("tap1_addr",        {24'd0, cap_addr[1]},   32'd1);
    chk("row1_start_addr",  {24'd0, cap_addr[5]},   32'd12);
    chk("row2_start_addr",  {24'd0, cap_addr[10]},  32'd24);
    chk("win0_last_addr",   {24'd0, cap_addr[24]},  32'd52);
    chk("win1_first_addr",  {24'd0, cap_addr[25]},  32'd1);
    chk("win_oy1_first",    {24'd0, cap_addr[200]}, 32'd12);
    chk("final_addr",       {24'd0, last_addr},     32'd143);
`else
    chk("first_real_addr",  {24'd0, cap_addr[0]},   32'd0);
    chk("final_addr",       {24'd0, last_addr},     32'd143);
`endif

    // Pass B: pseudo-random stalls, sequence must be unchanged.
    run_pass(1'b1, 1'b0, -1, ab);

    // Pass C: reset at tap 700, then a fresh pass replays from addr 0.
    run_pass(1'b0, 1'b0, 700, ab);
    chk("pass_aborted", {31'd0, ab}, 32'd1);
    run_pass(1'b0, 1'b0, -1, ab);
    chk("replay_first_addr", {24'd0, cap_addr[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
